joy_serial_responder: RTL and testbench



---
 rtl/joy_serial_responder_if.sv | 19 +
 rtl/joy_serial_responder.sv | 154 +++++++++++++++
 tb/tb_joy_serial_responder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/joy_serial_responder_if.sv
// Serial joystick link between the arcade master and the device-side responder.
// The master drives clock and load; the responder returns the serial data.
interface joy_serial_responder_if;
  logic joy_clk;
  logic joy_load;
  logic joy_data;

  modport master (
    output joy_clk,
    output joy_load,
    input  joy_data
  );

  modport slave (
    input  joy_clk,
    input  joy_load,
    output joy_data
  );
endinterface

// File: rtl/joy_serial_responder.sv
// Device end of the 24-bit joystick shift chain, oversampled in the clk domain.
// Optional input debounce is built when JOY_SER_DEBOUNCE_EN is defined.
module joy_serial_responder #(
  parameter int WATCHDOG_CYCLES = 1048576,
  parameter int DEBOUNCE_DIV    = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  joy_serial_responder_if.slave   link,
  input  logic [11:0]             joy1,
  input  logic [11:0]             joy2,
  output logic                    busy,
  output logic                    link_ok
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

  state_t          state;
  logic            ck_s1, ck_s2, ck_s3;
  logic            ld_s1, ld_s2, ld_s3;
  logic            ck_rise, ld_fall, ld_rise;
  logic [23:0]     in_s1, in_s2;
  logic [23:0]     ctl;
  logic [23:0]     frame;
  logic [23:0]     snapshot;
  logic [4:0]      bitcnt;
  logic [WD_W-1:0] wd_cnt;

  // Strobes idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_s1 <= 1'b1;
      ck_s2 <= 1'b1;
      ck_s3 <= 1'b1;
      ld_s1 <= 1'b1;
      ld_s2 <= 1'b1;
      ld_s3 <= 1'b1;
      in_s1 <= '1;
      in_s2 <= '1;
    end else begin
      ck_s1 <= link.joy_clk;
      ck_s2 <= ck_s1;
      ck_s3 <= ck_s2;
      ld_s1 <= link.joy_load;
      ld_s2 <= ld_s1;
      ld_s3 <= ld_s2;
      in_s1 <= {joy2, joy1};
      in_s2 <= in_s1;
    end
  end

  assign ck_rise = ck_s2 & ~ck_s3;
  assign ld_fall = ~ld_s2 & ld_s3;
  assign ld_rise = ld_s2 & ~ld_s3;

`ifdef JOY_SER_DEBOUNCE_EN
  localparam int DIV_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [23:0]      prev_sample;
  logic [23:0]      deb;

  // A bit only follows the input once two consecutive divided samples agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      prev_sample <= '1;
      deb         <= '1;
    end else if (div_cnt == DIV_W'(DEBOUNCE_DIV - 1)) begin
      div_cnt     <= '0;
      prev_sample <= in_s2;
      deb         <= (in_s2 & ~(in_s2 ^ prev_sample)) | (deb & (in_s2 ^ prev_sample));
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign ctl = deb;
`else
  logic [31:0] unused_div;
  assign unused_div = 32'(DEBOUNCE_DIV);
  assign ctl = in_s2;
`endif

  // ctl holds {joy2, joy1}; MSB of frame is the first bit sent to the master.
  assign frame = {ctl[8],  ctl[6],  ctl[5:0],
                  ctl[20], ctl[18], ctl[17:12],
                  ctl[22], ctl[23], ctl[21], ctl[19],
                  ctl[10], ctl[11], ctl[9],  ctl[7]};

  // Load low overrides every state, so a partial frame is silently abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      snapshot      <= '1;
      bitcnt        <= '0;
      link.joy_data <= 1'b1;
    end else if (!ld_s2) begin
      state         <= LOAD;
      snapshot      <= frame;
      bitcnt        <= '0;
      link.joy_data <= frame[23];
    end else begin
      case (state)
        IDLE: link.joy_data <= 1'b1;
        LOAD: begin
          if (ld_rise) begin
            state         <= SHIFT;
            link.joy_data <= snapshot[23];
          end
        end
        SHIFT: begin
          if (ck_rise) begin
            snapshot <= {snapshot[22:0], 1'b1};
            if (bitcnt == 5'd23) begin
              bitcnt        <= 5'd24;
              state         <= DONE;
              link.joy_data <= 1'b1;
            end else begin
              bitcnt        <= bitcnt + 5'd1;
              link.joy_data <= snapshot[22];
            end
          end
        end
        DONE: link.joy_data <= 1'b1;
        default: begin
          state         <= IDLE;
          link.joy_data <= 1'b1;
        end
      endcase
    end
  end

  assign busy = (state == SHIFT);

  // link_ok drops on the cycle the silence counter reaches its limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      link_ok <= 1'b0;
    end else if (ld_fall) begin
      wd_cnt  <= '0;
      link_ok <= 1'b1;
    end else if (wd_cnt != WD_W'(WATCHDOG_CYCLES)) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1)) begin
        link_ok <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_joy_serial_responder.sv
// Scoreboard bench for joy_serial_responder: the driver queues the bits the master
// should see, a monitor pops one per joy_clk rising edge and compares.
`timescale 1ns/1ps
module tb_joy_serial_responder;

  localparam int SETTLE = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] joy1, joy2;
  logic        busy, link_ok;

  joy_serial_responder_if sif ();

  joy_serial_responder #(
    .WATCHDOG_CYCLES(100),
    .DEBOUNCE_DIV   (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .link   (sif),
    .joy1   (joy1),
    .joy2   (joy2),
    .busy   (busy),
    .link_ok(link_ok)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic exp_q[$];
  int   idx_q[$];

  logic [11:0] cap1, cap2;
  int          shift_idx;

  // Frame order as a table: which player and which control bit each slot carries.
  int map_player [24] = '{1,1,1,1,1,1,1,1, 2,2,2,2,2,2,2,2, 2,2,2,2, 1,1,1,1};
  int map_bit    [24] = '{8,6,5,4,3,2,1,0, 8,6,5,4,3,2,1,0, 10,11,9,7, 10,11,9,7};

  function automatic logic expectedBit(int i, logic [11:0] a, logic [11:0] b);
    if (i >= 24) return 1'b1;
    return (map_player[i] == 1) ? a[map_bit[i]] : b[map_bit[i]];
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] required);
    n_compared++;
    if (actual !== required) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic waitClk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic startFrame(logic [11:0] a, logic [11:0] b);
    joy1 = a;
    joy2 = b;
    waitClk(SETTLE);
    cap1 = a;
    cap2 = b;
    shift_idx = 0;
    sif.joy_load = 1'b0;
    waitClk(8);
    sif.joy_load = 1'b1;
    waitClk(8);
    checkOutput("busy_in_shift", 32'(busy), 32'd1);
  endtask

  task automatic applyStimulus(int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(expectedBit(shift_idx, cap1, cap2));
      idx_q.push_back(shift_idx);
      shift_idx++;
      sif.joy_clk = 1'b1;
      waitClk(16);
      sif.joy_clk = 1'b0;
      waitClk(16);
    end
  endtask

  // The master samples the line on its own rising clock edge.
  always @(posedge sif.joy_clk) begin
    if (exp_q.size() > 0) begin
      logic e;
      int   idx;
      e   = exp_q.pop_front();
      idx = idx_q.pop_front();
      checkOutput($sformatf("frame_bit%0d", idx), 32'(sif.joy_data), 32'(e));
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL timeout: bench did not complete, got running, required finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n        = 1'b0;
    sif.joy_clk  = 1'b0;
    sif.joy_load = 1'b1;
    joy1         = '1;
    joy2         = '1;
    cap1         = '1;
    cap2         = '1;
    shift_idx    = 0;
    waitClk(4);
    checkOutput("reset_joy_data", 32'(sif.joy_data), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_link_ok", 32'(link_ok), 32'd0);
    rst_n = 1'b1;
    waitClk(150);
    checkOutput("link_ok_before_load", 32'(link_ok), 32'd0);

    // Watchdog: set three cycles after the first load low, drops 100 cycles later.
    sif.joy_load = 1'b0;
    repeat (2) @(posedge clk);
    #1 checkOutput("link_ok_2cyc", 32'(link_ok), 32'd0);
    @(posedge clk);
    #1 checkOutput("link_ok_3cyc", 32'(link_ok), 32'd1);
    repeat (99) @(posedge clk);
    #1 checkOutput("link_ok_before_expiry", 32'(link_ok), 32'd1);
    @(posedge clk);
    #1 checkOutput("link_ok_expired", 32'(link_ok), 32'd0);
    @(negedge clk);
    sif.joy_load = 1'b1;
    waitClk(8);

    // Full frame followed by surplus clocks.
    startFrame(12'hFFE, 12'hF7F);
    checkOutput("link_ok_relinked", 32'(link_ok), 32'd1);
    applyStimulus(24);
    waitClk(4);
    checkOutput("busy_after_frame", 32'(busy), 32'd0);
    checkOutput("idle_data_after_frame", 32'(sif.joy_data), 32'd1);
    applyStimulus(10);
    checkOutput("busy_after_extra", 32'(busy), 32'd0);
    checkOutput("bitcnt_saturated", 32'(dut.bitcnt), 32'd24);

    // Abort a partial frame with changed inputs.
    startFrame(12'($urandom), 12'($urandom));
    applyStimulus(9);
    startFrame(12'h0FF, 12'($urandom));
    applyStimulus(24);

    // Collision: load falls and clk rises on the same edge.
    joy1 = 12'($urandom);
    joy2 = 12'($urandom);
    waitClk(SETTLE);
    cap1 = joy1;
    cap2 = joy2;
    sif.joy_load = 1'b0;
    sif.joy_clk  = 1'b1;
    waitClk(6);
    checkOutput("collision_busy", 32'(busy), 32'd0);
    checkOutput("collision_bitcnt", 32'(dut.bitcnt), 32'd0);
    checkOutput("collision_bit0", 32'(sif.joy_data), 32'(expectedBit(0, cap1, cap2)));
    sif.joy_clk = 1'b0;
    waitClk(4);
    sif.joy_load = 1'b1;
    shift_idx = 0;
    waitClk(8);
    applyStimulus(24);

    // Random frames with random abort points.
    for (int i = 0; i < 5; i++) begin
      startFrame(12'($urandom), 12'($urandom));
      applyStimulus(int'($urandom_range(1, 28)));
    end

    // Reset in the middle of a frame.
    startFrame(12'($urandom), 12'($urandom));
    applyStimulus(5);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_joy_data", 32'(sif.joy_data), 32'd1);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_link_ok", 32'(link_ok), 32'd0);
    waitClk(2);
    rst_n = 1'b1;
    waitClk(4);
    shift_idx = 24;
    applyStimulus(3);
    checkOutput("post_reset_idle_busy", 32'(busy), 32'd0);
    startFrame(12'($urandom), 12'($urandom));
    applyStimulus(24);

`ifdef JOY_SER_DEBOUNCE_EN
    // A three-cycle glitch during load must not reach the snapshot.
    joy1 = '1;
    joy2 = 12'($urandom);
    waitClk(SETTLE);
    cap1 = '1;
    cap2 = joy2;
    sif.joy_load = 1'b0;
    joy1[0] = 1'b0;
    waitClk(3);
    joy1[0] = 1'b1;
    waitClk(12);
    sif.joy_load = 1'b1;
    shift_idx = 0;
    waitClk(8);
    applyStimulus(24);

    // A level held for ten cycles is captured.
    sif.joy_load = 1'b0;
    joy1[0] = 1'b0;
    cap1 = 12'hFFE;
    waitClk(10);
    sif.joy_load = 1'b1;
    joy1[0] = 1'b1;
    shift_idx = 0;
    waitClk(8);
    applyStimulus(24);
`endif

    waitClk(8);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
